avalon_gpio_pio: RTL and testbench

Parametrised Avalon-MM general-purpose I/O block: the successor to the fixed 7-bit output-only PIO. It adds per-bit direction control, a synchronised input path, edge capture and a maskable interrupt. It sits on the Nios system interconnect as a single slave and drives board pins (LEDs, 7-segment displays, switches, buttons) through an external tri-state or direct wiring.

---
 rtl/avalon_gpio_pio.sv | 117 +++++++++++
 tb/tb_avalon_gpio_pio.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/avalon_gpio_pio.sv
// Avalon-MM GPIO slave: data/direction/mask/edge-capture registers, synchronised inputs, maskable irq.
// Optional OUTSET/OUTCLEAR registers at addresses 4/5 are built when AVALON_GPIO_BITSET_EN is defined.
module avalon_gpio_pio #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam int WARM = SYNC_STAGES + 1;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [2:0]       warm_q;

  logic             wr_en;
  logic             warm_done;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rd_val;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign sync_last    = sync_q[SYNC_STAGES-1];
  assign warm_done    = (warm_q == 3'(WARM));

  // Edges are masked until the synchroniser and prev register hold post-reset pin values.
  always_comb begin
    case (EDGE_TYPE)
      0:       edge_raw = sync_last & ~prev_q;
      1:       edge_raw = ~sync_last & prev_q;
      default: edge_raw = sync_last ^ prev_q;
    endcase
    edge_det = warm_done ? edge_raw : '0;
  end

  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    clr    = '0;
    if (wr_en) begin
      case (address)
        3'd0: data_d = wdata;
        3'd1: dir_d  = wdata;
        3'd2: mask_d = wdata;
        3'd3: clr    = wdata;
`ifdef AVALON_GPIO_BITSET_EN
        3'd4: data_d = data_q | wdata;
        3'd5: data_d = data_q & ~wdata;
`endif
        default: ;
      endcase
    end
    // A new edge in the clearing cycle wins over write-1-to-clear.
    cap_d = (cap_q & ~clr) | edge_det;
  end

  always_comb begin
    case (address)
      3'd0:    rd_val = sync_last;
      3'd1:    rd_val = dir_q;
      3'd2:    rd_val = mask_q;
      3'd3:    rd_val = cap_q;
      default: rd_val = '0;
    endcase
    readdata            = '0;
    readdata[WIDTH-1:0] = rd_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      dir_q  <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      prev_q <= '0;
      warm_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      data_q    <= data_d;
      dir_q     <= dir_d;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      prev_q    <= sync_last;
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      if (!warm_done) warm_q <= warm_q + 3'd1;
    end
  end

  assign gpio_out = data_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_avalon_gpio_pio.sv
// Scoreboard bench for avalon_gpio_pio: instance A (rising edge, reset 0xA5), instance B (any edge).
module tb_avalon_gpio_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        cs_a, cs_b, write_n;
  logic [31:0] writedata;
  logic [31:0] rd_a, rd_b;
  logic [7:0]  in_a, in_b, out_a, out_b, oe_a, oe_b;
  logic        irq_a, irq_b;

  always #5 clk = ~clk;

  avalon_gpio_pio #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a), .gpio_in(in_a), .gpio_out(out_a), .gpio_oe(oe_a),
    .irq(irq_a));

  avalon_gpio_pio #(.WIDTH(8), .RESET_VALUE(8'h00), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b), .write_n(write_n),
    .writedata(writedata), .readdata(rd_b), .gpio_in(in_b), .gpio_out(out_b), .gpio_oe(oe_b),
    .irq(irq_b));

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sb_q[$];
  logic chk_vld;
  int   n_cmp, n_bad;

  // Monitor: pops one expectation per presented check strobe, sampled on the falling edge.
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    if (chk_vld) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: check strobe with no expectation queued");
      end else begin
        c = sb_q.pop_front();
        case (c.sel)
          0:       act = rd_a;
          1:       act = rd_b;
          2:       act = {24'h0, out_a};
          3:       act = {24'h0, oe_a};
          4:       act = {31'h0, irq_a};
          5:       act = {24'h0, out_b};
          default: act = {31'h0, irq_b};
        endcase
        if (act !== c.exp) begin
          n_bad++;
          $display("FAIL %s: got %h, required %h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic sel_b, input logic [2:0] a, input logic [31:0] d);
    cs_a = ~sel_b; cs_b = sel_b; write_n = 1'b0; address = a; writedata = d;
    tick();
    cs_a = 1'b0; cs_b = 1'b0; write_n = 1'b1;
  endtask

  task automatic expect_sig(input string name, input int sel, input logic [31:0] exp);
    chk_t c;
    c.name = name; c.sel = sel; c.exp = exp;
    sb_q.push_back(c);
    chk_vld = 1'b1;
    tick();
    chk_vld = 1'b0;
  endtask

  task automatic rd(input string name, input logic sel_b, input logic [2:0] a, input logic [31:0] exp);
    cs_a = ~sel_b; cs_b = sel_b; write_n = 1'b1; address = a;
    expect_sig(name, sel_b ? 1 : 0, exp);
    cs_a = 1'b0; cs_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_set, exp_clr;
`ifdef AVALON_GPIO_BITSET_EN
    exp_set = 32'h3F; exp_clr = 32'h3A;
`else
    exp_set = 32'h0F; exp_clr = 32'h0F;
`endif
    n_cmp = 0; n_bad = 0; chk_vld = 1'b0;
    reset_n = 1'b0; cs_a = 1'b0; cs_b = 1'b0; write_n = 1'b1;
    address = '0; writedata = '0; in_a = 8'h00; in_b = 8'hFF;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    expect_sig("rst_out_a", 2, 32'hA5);
    expect_sig("rst_oe_a", 3, 32'h00);
    expect_sig("rst_irq_a", 4, 32'h0);
    rd("rst_data_a", 1'b0, 3'd0, 32'h00);
    rd("rst_dir_a", 1'b0, 3'd1, 32'h00);
    rd("rst_mask_a", 1'b0, 3'd2, 32'h00);
    rd("rst_cap_a", 1'b0, 3'd3, 32'h00);
    rd("unmapped6_a", 1'b0, 3'd6, 32'h00);
    expect_sig("rst_out_b", 5, 32'h00);
    tick(4);
    rd("warmup_cap_b", 1'b1, 3'd3, 32'h00);

    wr(1'b0, 3'd0, 32'h3C);
    expect_sig("data_wr_out", 2, 32'h3C);
    wr(1'b0, 3'd1, 32'hFF);
    expect_sig("dir_wr_oe", 3, 32'hFF);
    rd("dir_readback", 1'b0, 3'd1, 32'hFF);

    in_a = 8'h81;
    tick();
    rd("data_sync_lag", 1'b0, 3'd0, 32'h00);
    rd("data_sync", 1'b0, 3'd0, 32'h81);
    rd("cap_rise_81", 1'b0, 3'd3, 32'h81);
    wr(1'b0, 3'd3, 32'hFF);
    rd("cap_cleared", 1'b0, 3'd3, 32'h00);

    in_a = 8'h00;
    tick(4);
    rd("falling_ignored", 1'b0, 3'd3, 32'h00);

    wr(1'b0, 3'd2, 32'h01);
    expect_sig("irq_masked_idle", 4, 32'h0);
    in_a = 8'h01;
    tick(2);
    expect_sig("irq_before_edge", 4, 32'h0);
    expect_sig("irq_after_edge", 4, 32'h1);
    rd("cap_bit0", 1'b0, 3'd3, 32'h01);
    wr(1'b0, 3'd3, 32'h01);
    expect_sig("irq_after_clear", 4, 32'h0);
    rd("cap_after_clear", 1'b0, 3'd3, 32'h00);

    in_a = 8'h00; tick(4);
    in_a = 8'h01; tick(4);
    in_a = 8'h00; tick(4);
    rd("cap_sticky", 1'b0, 3'd3, 32'h01);
    in_a = 8'h01;
    tick(2);
    wr(1'b0, 3'd3, 32'h01);
    expect_sig("collision_irq", 4, 32'h1);
    rd("collision_cap", 1'b0, 3'd3, 32'h01);
    wr(1'b0, 3'd3, 32'h01);
    rd("collision_cleanup", 1'b0, 3'd3, 32'h00);

    in_b = 8'hF7; tick(4);
    in_b = 8'hFF; tick(4);
    rd("any_edge_cap_b", 1'b1, 3'd3, 32'h08);
    rd("data_b", 1'b1, 3'd0, 32'hFF);

    wr(1'b1, 3'd0, 32'h0F);
    expect_sig("bitset_base", 5, 32'h0F);
    wr(1'b1, 3'd4, 32'h30);
    expect_sig("outset", 5, exp_set);
    wr(1'b1, 3'd5, 32'h05);
    expect_sig("outclear", 5, exp_clr);
    rd("addr4_reads0", 1'b1, 3'd4, 32'h00);
    rd("addr5_reads0", 1'b1, 3'd5, 32'h00);

    #3 reset_n = 1'b0;
    expect_sig("midrst_out_a", 2, 32'hA5);
    expect_sig("midrst_irq_b", 6, 32'h0);
    reset_n = 1'b1;
    expect_sig("midrst_out_b", 5, 32'h00);
    expect_sig("midrst_oe_a", 3, 32'h00);
    tick(4);
    rd("rewarm_cap_b", 1'b1, 3'd3, 32'h00);
    rd("rewarm_cap_a", 1'b0, 3'd3, 32'h00);
    rd("data_after_rst_a", 1'b0, 3'd0, 32'h01);

    tick(2);
    if (sb_q.size() != 0) begin
      n_cmp += sb_q.size();
      n_bad += sb_q.size();
      $display("FAIL scoreboard_drain: %0d pending, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
